pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline stage register; generic successor to the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/sat_counter.sv | 25 ++
 rtl/pipe_stage_elastic.sv | 127 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline stages.
// Carries the EX/MEM field widths and the control-bit positions.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int unsigned EXMEM_DATA_W = 101;
  localparam int unsigned EXMEM_CTRL_W = 9;

  // EX/MEM control field layout: {zero, branch[1:0], jump[1:0], memr, memw, regw, mem2r}
  localparam int unsigned EXMEM_ZERO      = 8;
  localparam int unsigned EXMEM_BRANCH_HI = 7;
  localparam int unsigned EXMEM_BRANCH_LO = 6;
  localparam int unsigned EXMEM_JUMP_HI   = 5;
  localparam int unsigned EXMEM_JUMP_LO   = 4;
  localparam int unsigned EXMEM_MEMR      = 3;
  localparam int unsigned EXMEM_MEMW      = 2;
  localparam int unsigned EXMEM_REGW      = 1;
  localparam int unsigned EXMEM_MEM2R     = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, optional 2-entry skid buffer,
// bubbles carry an all-zero control field, saturating stall-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = EXMEM_DATA_W,
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occ       = occ_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occ_d       = occ_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          occ_d       = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire && SKID) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          occ_d       = OCC_TWO;
        end else if (out_fire) begin
          main_ctrl_d = '0;
          occ_d       = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          occ_d       = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    // Flush drops any entry (including a concurrent accept) but leaves data stale.
    if (flush) begin
      occ_d       = OCC_EMPTY;
      main_data_d = main_data_q;
      main_ctrl_d = '0;
      skid_data_d = skid_data_q;
      skid_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      occ_q       <= occ_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
          rdy_q       <= 1'b0;
        end else begin
          skid_data_q <= skid_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          rdy_q       <= (occ_d != OCC_TWO);
        end
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign skid_data_q = '0;
      assign skid_ctrl_q = '0;
      assign in_ready    = rst_n & (~out_valid | out_ready);
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .inc_i  (out_valid & ~out_ready & ~flush),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench: vector table on a SKID=1 stage, hand sequences for async reset
// and for a SKID=0 stage with a 4-bit stall counter.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int unsigned DW = EXMEM_DATA_W;
  localparam int unsigned CW = EXMEM_CTRL_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic          rst_n1, flush1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [DW-1:0] in_data1, out_data1;
  logic [CW-1:0] in_ctrl1, out_ctrl1;
  logic [1:0]    occ1;
  logic [15:0]   stall1;

  // SKID=0, CNT_W=4 instance
  logic          rst_n0, flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [DW-1:0] in_data0, out_data0;
  logic [CW-1:0] in_ctrl0, out_ctrl0;
  logic [1:0]    occ0;
  logic [3:0]    stall0;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) u_skid1 (
    .clk(clk), .rst_n(rst_n1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_ctrl(in_ctrl1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_ctrl(out_ctrl1), .occ(occ1), .stall_cnt(stall1)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(4)) u_skid0 (
    .clk(clk), .rst_n(rst_n0), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_ctrl(in_ctrl0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_ctrl(out_ctrl0), .occ(occ0), .stall_cnt(stall0)
  );

  typedef struct {
    logic        iv, ord, fl;
    logic [7:0]  d;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic vec_t mk(logic iv, logic ord, logic fl, logic [7:0] d,
                              logic ov, logic [7:0] od, logic [1:0] oc, logic ir,
                              logic [15:0] st);
    vec_t v;
    v.iv = iv; v.ord = ord; v.fl = fl; v.d = d;
    v.ov = ov; v.od = od; v.occ = oc; v.ir = ir; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input logic [7:0] d);
    return {1'b1, d};
  endfunction

  initial begin
    rst_n1 = 1'b0; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_data1 = '0; in_ctrl1 = '0;
    rst_n0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    in_data0 = '0; in_ctrl0 = '0;

    // Streaming 1..8
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 1, 0, 8'(k), 1, 8'(k), 2'd1, 1, 16'd0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h08, 2'd0, 1, 16'd0));
    // Backpressure A,B,C
    vecs.push_back(mk(1, 1, 0, 8'h0A, 1, 8'h0A, 2'd1, 1, 16'd0));
    vecs.push_back(mk(1, 0, 0, 8'h0B, 1, 8'h0A, 2'd2, 0, 16'd1));
    vecs.push_back(mk(1, 0, 0, 8'h0C, 1, 8'h0A, 2'd2, 0, 16'd2));
    vecs.push_back(mk(1, 0, 0, 8'h0C, 1, 8'h0A, 2'd2, 0, 16'd3));
    vecs.push_back(mk(1, 1, 0, 8'h0C, 1, 8'h0B, 2'd1, 1, 16'd3));
    vecs.push_back(mk(1, 1, 0, 8'h0C, 1, 8'h0C, 2'd1, 1, 16'd3));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h0C, 2'd0, 1, 16'd3));
    // Flush at occ=2 with in_valid=1
    vecs.push_back(mk(1, 0, 0, 8'h0D, 1, 8'h0D, 2'd1, 1, 16'd3));
    vecs.push_back(mk(1, 0, 0, 8'h0E, 1, 8'h0D, 2'd2, 0, 16'd4));
    vecs.push_back(mk(1, 0, 1, 8'h0F, 0, 8'h0D, 2'd0, 1, 16'd4));
    vecs.push_back(mk(1, 1, 0, 8'h16, 1, 8'h16, 2'd1, 1, 16'd4));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h16, 2'd0, 1, 16'd4));
    // Flush at occ=1 with concurrent in_fire and out_fire
    vecs.push_back(mk(1, 0, 0, 8'h17, 1, 8'h17, 2'd1, 1, 16'd4));
    vecs.push_back(mk(1, 1, 1, 8'h18, 0, 8'h17, 2'd0, 1, 16'd4));
    vecs.push_back(mk(1, 1, 0, 8'h19, 1, 8'h19, 2'd1, 1, 16'd4));
    // Fill to occ=2 ahead of the async reset
    vecs.push_back(mk(1, 0, 0, 8'h20, 1, 8'h19, 2'd2, 0, 16'd5));

    // Reset state
    @(negedge clk);
    chk("rst_ov1", out_valid1, 0);
    chk("rst_ir1", in_ready1, 0);
    chk("rst_occ1", occ1, 0);
    chk("rst_ctrl1", out_ctrl1, 0);
    chk("rst_stall1", stall1, 0);
    chk("rst_ir0", in_ready0, 0);
    rst_n1 = 1'b1;
    rst_n0 = 1'b1;
    @(negedge clk);
    chk("post_rst_ir1", in_ready1, 1);

    foreach (vecs[i]) begin
      in_valid1  = vecs[i].iv;
      out_ready1 = vecs[i].ord;
      flush1     = vecs[i].fl;
      in_data1   = DW'(vecs[i].d);
      in_ctrl1   = ctrl_of(vecs[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_ov", i), out_valid1, vecs[i].ov);
      chk($sformatf("v%0d_od", i), out_data1, 128'(vecs[i].od));
      chk($sformatf("v%0d_ctrl", i), out_ctrl1,
          vecs[i].ov ? 128'(ctrl_of(vecs[i].od)) : 128'd0);
      chk($sformatf("v%0d_occ", i), occ1, vecs[i].occ);
      chk($sformatf("v%0d_ir", i), in_ready1, vecs[i].ir);
      chk($sformatf("v%0d_stall", i), stall1, vecs[i].stall);
    end

    // Async reset mid-cycle at occ=2
    in_valid1 = 1'b0; out_ready1 = 1'b0; flush1 = 1'b0;
    #2 rst_n1 = 1'b0;
    #1;
    chk("arst_ov", out_valid1, 0);
    chk("arst_ctrl", out_ctrl1, 0);
    chk("arst_data", out_data1, 0);
    chk("arst_occ", occ1, 0);
    chk("arst_ir", in_ready1, 0);
    chk("arst_stall", stall1, 0);
    @(negedge clk);
    rst_n1 = 1'b1;
    @(negedge clk);
    chk("arst_rel_ir", in_ready1, 1);
    chk("arst_rel_ov", out_valid1, 0);
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    in_data1 = DW'(8'h21); in_ctrl1 = ctrl_of(8'h21);
    @(posedge clk); #1;
    chk("arst_first_ov", out_valid1, 1);
    chk("arst_first_od", out_data1, 128'h21);
    chk("arst_first_ctrl", out_ctrl1, 128'(ctrl_of(8'h21)));
    in_valid1 = 1'b0;

    // SKID=0: combinational in_ready and bubble-free pass-through
    @(negedge clk);
    in_valid0 = 1'b1; out_ready0 = 1'b0;
    in_data0 = DW'(8'h01); in_ctrl0 = ctrl_of(8'h01);
    #1 chk("s0_ir_empty", in_ready0, 1);
    @(posedge clk); #1;
    chk("s0_ov1", out_valid0, 1);
    chk("s0_od1", out_data0, 128'h01);
    chk("s0_ir_blocked", in_ready0, 0);
    out_ready0 = 1'b1;
    #1 chk("s0_ir_released", in_ready0, 1);
    in_data0 = DW'(8'h02); in_ctrl0 = ctrl_of(8'h02);
    @(posedge clk); #1;
    chk("s0_ov2", out_valid0, 1);
    chk("s0_od2", out_data0, 128'h02);
    chk("s0_ir2", in_ready0, 1);
    in_data0 = DW'(8'h03); in_ctrl0 = ctrl_of(8'h03);
    @(posedge clk); #1;
    chk("s0_ov3", out_valid0, 1);
    chk("s0_od3", out_data0, 128'h03);
    chk("s0_ctrl3", out_ctrl0, 128'(ctrl_of(8'h03)));

    // 4-bit stall counter saturates at 15
    in_valid0 = 1'b0; out_ready0 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_%0d", i), stall0, (i > 15) ? 15 : i);
      chk($sformatf("sat_occ_%0d", i), occ0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
